// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Contents: DATA_W datapath width, ALU opcode constants and the
// sequencer state type.
package alu_arbiter_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ZERO = 3'b101;
  localparam logic [2:0] OP_SHLA = 3'b110;
  localparam logic [2:0] OP_SHLB = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 8-bit ALU.
// Ports:
//   a, b       operands
//   op         opcode (see alu_arbiter_pkg)
//   carry_in   added into add/sub (1 turns a + ~b into a - b)
//   result     ALU result
//   carry_out  raw carry-out of the adder; only meaningful for add/sub
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] cin_ext;

  assign cin_ext = {{DATA_W{1'b0}}, carry_in};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    sum       = '0;
    result    = '0;
    carry_out = 1'b0;
    case (op)
      OP_ADD: begin
        sum       = {1'b0, a} + {1'b0, b} + cin_ext;
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      OP_SUB: begin
        sum       = {1'b0, a} + {1'b0, ~b} + cin_ext;
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_ZERO: result = '0;
      OP_SHLA: result = {a[DATA_W-2:0], 1'b0};
      OP_SHLB: result = {b[DATA_W-2:0], 1'b0};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one ALU between two
// requesters. One operation in flight: IDLE accepts, EXEC drives the ALU
// from latched operands, RESP holds the tagged result until consumed.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake, N = 0, 1
//   reqN_a, reqN_b, reqN_op   request payload
//   resp_valid/ready          response handshake
//   resp_id                   index of the requester that issued the op
//   resp_result/carry/zero/cflag  registered ALU result and flags
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_carry,
  output logic              resp_zero,
  output logic              resp_cflag
);

  state_t            state, state_next;
  logic              last_grant;
  logic              grant_id;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b;
  logic [2:0]        op_code;
  logic              op_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_carry_in;
  logic              carry_masked;

  // Winner when both are valid: the one not granted last (or req0 if fixed).
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign alu_carry_in = (op_code == OP_SUB);
  assign carry_masked = alu_carry && ((op_code == OP_ADD) || (op_code == OP_SUB));

  alu_arbiter_alu u_alu (
    .a         (op_a),
    .b         (op_b),
    .op        (op_code),
    .carry_in  (alu_carry_in),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_zero   <= 1'b0;
      resp_cflag  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        resp_id     <= op_id;
        resp_result <= alu_result;
        resp_carry  <= carry_masked;
        resp_zero   <= (alu_result == '0);
        resp_cflag  <= (op_a >= op_b);
      end
    end
  end

  // NOTE: the operand registers carry no reset; they are only read in EXEC,
  // which can only be reached through a handshake that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a    <= grant_id ? req1_a  : req0_a;
      op_b    <= grant_id ? req1_b  : req0_b;
      op_code <= grant_id ? req1_op : req0_op;
      op_id   <= grant_id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized section against a behavioural model.
// A second instance with FIXED_PRIO=1 sees identical stimulus; its FSM moves
// in lock-step with the first, so only its grant choice differs.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       resp_ready;

  logic       req0_ready, req1_ready, resp_valid, resp_id;
  logic [7:0] resp_result;
  logic       resp_carry, resp_zero, resp_cflag;

  logic       fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id;
  logic [7:0] fp_resp_result;
  logic       fp_resp_carry, fp_resp_zero, fp_resp_cflag;

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .resp_zero(resp_zero), .resp_cflag(resp_cflag)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
    .resp_result(fp_resp_result), .resp_carry(fp_resp_carry),
    .resp_zero(fp_resp_zero), .resp_cflag(fp_resp_cflag)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       cflag;
  } resp_t;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    resp_t      exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: plain integer arithmetic on the opcode definitions.
  function automatic resp_t model(input int a, input int b, input int op);
    resp_t m;
    int    r;
    m.carry = 1'b0;
    case (op)
      0: begin r = a + b; m.carry = (r > 255); end
      1: begin r = a - b; m.carry = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 0;
      6: r = a * 2;
      7: r = b * 2;
      default: r = 0;
    endcase
    m.result = r[7:0];
    m.zero   = (m.result == 8'h00);
    m.cflag  = (a >= b);
    return m;
  endfunction

  task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called just after a negedge; returns the winner, or -1 on timeout.
  task automatic wait_handshake(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      if (req0_valid && req0_ready) begin who = 0; break; end
      if (req1_valid && req1_ready) begin who = 1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic check_resp(input string tag, input int id, input resp_t e);
    check({tag, " resp_valid"},  resp_valid,  1);
    check({tag, " resp_id"},     resp_id,     id);
    check({tag, " resp_result"}, resp_result, e.result);
    check({tag, " resp_carry"},  resp_carry,  e.carry);
    check({tag, " resp_zero"},   resp_zero,   e.zero);
    check({tag, " resp_cflag"},  resp_cflag,  e.cflag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req0_ready"},  req0_ready,  0);
    check({tag, " req1_ready"},  req1_ready,  0);
    check({tag, " resp_valid"},  resp_valid,  0);
    check({tag, " resp_id"},     resp_id,     0);
    check({tag, " resp_result"}, resp_result, 0);
    check({tag, " resp_carry"},  resp_carry,  0);
    check({tag, " resp_zero"},   resp_zero,   0);
    check({tag, " resp_cflag"},  resp_cflag,  0);
  endtask

  // One isolated operation with latency checks; expects resp_ready high.
  task automatic run_single(input string tag, input int id, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] op, input resp_t e);
    int who;
    @(negedge clk);
    drive_req(id, a, b, op);
    #1;
    wait_handshake(who);
    check({tag, " grant"}, who, id);
    @(negedge clk);
    clear_reqs();
    #1;
    check({tag, " no resp in N+1"}, resp_valid, 0);
    @(negedge clk); #1;
    check_resp(tag, id, e);
  endtask

  vec_t  vecs[6];
  int    exp_g[3];
  int    who;
  int    model_last;
  resp_t e;

  initial begin
    rst = 1'b1;
    clear_reqs();
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Contention from reset: round-robin alternates, fixed priority stays on req0.
    exp_g = '{0, 1, 0};
    @(negedge clk);
    drive_req(0, 8'h01, 8'h02, OP_ADD);
    drive_req(1, 8'hF0, 8'h0F, OP_XOR);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rr req0_ready", req0_ready, exp_g[k] == 0);
      check("rr req1_ready", req1_ready, exp_g[k] == 1);
      check("fp req0_ready", fp_req0_ready, 1);
      check("fp req1_ready", fp_req1_ready, 0);
      @(negedge clk); #1;
      check("rr exec ready0", req0_ready, 0);
      check("rr exec ready1", req1_ready, 0);
      @(negedge clk); #1;
      check("rr resp ready", req0_ready | req1_ready, 0);
      e = (exp_g[k] == 0) ? model(8'h01, 8'h02, 0) : model(8'hF0, 8'h0F, 4);
      check_resp("rr", exp_g[k], e);
      check("fp resp_id", fp_resp_id, 0);
      @(negedge clk); #1;
    end
    clear_reqs();

    // Directed vector table.
    vecs[0] = '{0, 8'h7F, 8'h01, OP_ADD,  '{8'h80, 1'b0, 1'b0, 1'b1}};
    vecs[1] = '{1, 8'h05, 8'h05, OP_SUB,  '{8'h00, 1'b1, 1'b1, 1'b1}};
    vecs[2] = '{1, 8'h03, 8'h05, OP_SUB,  '{8'hFE, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{0, 8'h81, 8'h10, OP_SHLA, '{8'h02, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{0, 8'h33, 8'hC0, OP_SHLB, '{8'h80, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{0, 8'h12, 8'h34, OP_ZERO, '{8'h00, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                 vecs[i].op, vecs[i].exp);
    end

    // Backpressure: response held 4 cycles while req0 waits.
    @(negedge clk);
    drive_req(1, 8'hC3, 8'h3C, OP_OR);
    #1;
    wait_handshake(who);
    check("stall grant", who, 1);
    @(negedge clk);
    clear_reqs();
    resp_ready = 1'b0;
    drive_req(0, 8'h20, 8'h30, OP_ADD);
    e = model(8'hC3, 8'h3C, 3);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); #1;
      check_resp($sformatf("stall%0d", s), 1, e);
      check("stall req0_ready", req0_ready, 0);
      check("stall req1_ready", req1_ready, 0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check_resp("release", 1, e);
    check("release no accept", req0_ready, 0);
    @(negedge clk); #1;
    check("after release idle", resp_valid, 0);
    check("after release accept", req0_ready, 1);
    @(negedge clk);
    clear_reqs();
    @(negedge clk); #1;
    check_resp("queued op", 0, model(8'h20, 8'h30, 0));

    // Reset in EXEC, then in RESP: no response, pointer back to 1.
    @(negedge clk);
    drive_req(0, 8'h09, 8'h04, OP_SUB);
    #1;
    wait_handshake(who);
    check("rst1 grant", who, 0);
    @(negedge clk);
    clear_reqs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst exec");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst exec silent", resp_valid, 0);
    end
    @(negedge clk);
    drive_req(0, 8'h10, 8'h20, OP_ADD);
    #1;
    wait_handshake(who);
    check("rst2 grant", who, 0);
    @(negedge clk);
    clear_reqs();
    @(negedge clk); #1;
    check_resp("rst2 pre", 0, model(8'h10, 8'h20, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst resp");
    @(negedge clk);
    drive_req(0, 8'h44, 8'h11, OP_AND);
    drive_req(1, 8'h55, 8'h66, OP_SUB);
    #1;
    check("post rst req0 wins", req0_ready, 1);
    check("post rst req1 waits", req1_ready, 0);
    @(negedge clk);
    clear_reqs();
    @(negedge clk); #1;
    check_resp("post rst", 0, model(8'h44, 8'h11, 2));

    // Randomized traffic against the model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1;
    for (int it = 0; it < 60; it++) begin
      int          mask, exp_w, stall;
      logic [7:0]  a0, b0, a1, b1;
      logic [2:0]  o0, o1;
      @(negedge clk);
      mask = $urandom_range(1, 3);
      a0 = 8'($urandom); b0 = 8'($urandom); o0 = 3'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); o1 = 3'($urandom);
      if (mask & 1) drive_req(0, a0, b0, o0);
      if (mask & 2) drive_req(1, a1, b1, o1);
      #1;
      if (mask == 3) exp_w = (model_last == 0) ? 1 : 0;
      else           exp_w = (mask == 1) ? 0 : 1;
      check("rand fp grant1", fp_req1_ready, (mask & 1) == 0);
      wait_handshake(who);
      check("rand grant", who, exp_w);
      model_last = exp_w;
      e = (exp_w == 0) ? model(a0, b0, o0) : model(a1, b1, o1);
      stall = $urandom_range(0, 2);
      @(negedge clk);
      clear_reqs();
      resp_ready = (stall == 0);
      @(negedge clk); #1;
      check_resp("rand", exp_w, e);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (s == stall - 1) resp_ready = 1'b1;
        #1;
        check_resp("rand hold", exp_w, e);
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU between two requesters. It sits between two operation sources (e.g. a control FSM and a host port) and the ALU datapath. Each operation is accepted with a valid/ready handshake, its operands are registered and driven into the ALU for one cycle, and the result and flags are returned on a single tagged response port with backpressure. One operation is in flight at a time.

## Interface
- FIXED_PRIO, default 0: 0 = round-robin; 1 = req0 always wins when both requesters are valid.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when high together with req0_valid.
- req0_a, req0_b  in  8 each  operands.
- req0_op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 zero, 110 a<<1, 111 b<<1.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0.
- resp_valid  out  1  response is available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester index of the response.
- resp_result  out  8  ALU result.
- resp_carry  out  1  ALU carry-out for opcodes 000/001; 0 for all other opcodes.
- resp_zero  out  1  result == 0x00.
- resp_cflag  out  1  a >= b (unsigned), reported for every opcode.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: req_ready is high only for the granted requester, and only when it is valid. On handshake the arbiter latches a, b, op and id, then moves to EXEC. With no valid requester it stays in IDLE.
- Arbitration (FIXED_PRIO=0):
  - Exactly one requester valid: that requester wins.
  - Both valid: the requester not granted last time wins.
  - The last-grant pointer resets to 1, so req0 wins the first contention.
  - The pointer updates only on a handshake.
- Arbitration (FIXED_PRIO=1): req0 wins whenever req0_valid is high.
- EXEC: the latched operands drive the ALU.
  - ALU carry_in = (op == 001); it is 0 for all other opcodes.
  - At the end of the cycle the arbiter captures result, carry (masked per resp_carry rule), zero and cflag into response registers.
  - Next state is RESP.
- RESP:
  - resp_valid is high, and all resp_* fields are held stable until resp_valid && resp_ready.
  - On that handshake the FSM moves to IDLE.
  - No new request is accepted while in EXEC or RESP.
- Requesters hold valid and payload stable until ready. The arbiter does not check a dropped valid.
- Arithmetic is 8-bit with wrap-around. Sub is a + ~b + 1, and carry=1 means no borrow. Shifts discard bit 7 and fill bit 0 with 0.
- Opcode 101 returns result 0x00, zero=1, carry=0.

## Timing
- Reset values: req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, resp_result=0x00, resp_carry=0, resp_zero=0, resp_cflag=0. Last-grant pointer = 1.
- Latency: a handshake in cycle N gives resp_valid high in cycle N+2.
- Throughput: with resp_ready held high, the next request handshake occurs at N+3 at the earliest. Maximum rate is one operation per 3 cycles.
- req_ready is combinational from the FSM state, the valids and the pointer. There is no combinational path from any req_* input to any resp_* output.
- rst asserted in any state: next cycle the FSM is in IDLE and all outputs are at reset values. An in-flight operation or pending response is discarded, and no response is issued for it.
- A simultaneous request valid and a resp handshake in RESP causes no accept that cycle. The request is accepted in the following IDLE cycle.

## Structure
- A shared package holds the opcode constants (OP_ADD through OP_SHLB), the FSM state type {IDLE, EXEC, RESP}, and the width constant DATA_W=8.
- The existing ALU module is the sole sub-module, instantiated once. The arbiter, operand registers, FSM and response registers live in alu_arbiter.
- The carry mask and ALU carry_in derivation are small combinational logic in this block, not in the ALU.

## Test plan
- req0 add 0x7F+0x01 alone → req0_ready at N, resp at N+2: id=0, result=0x80, carry=0, zero=0, cflag=1.
- req1 sub 0x05-0x05 → result=0x00, carry=1, zero=1, cflag=1. Then sub 0x03-0x05 → result=0xFE, carry=0, cflag=0.
- Both valid from reset with back-to-back ops → grants alternate req0, req1, req0. Each response id matches its requester. With FIXED_PRIO=1, req0 is granted every time.
- req0 op 110 a=0x81, then op 111 b=0xC0, then op 101 → results 0x02, 0x80, 0x00 (zero=1). carry=0 for all three.
- resp_ready low for 4 cycles in RESP → all resp_* fields stable, both req_ready=0. Handshake occurs on the cycle resp_ready rises, and IDLE follows.
- rst pulsed in EXEC and again in RESP → no response emitted, outputs return to reset values, and the next contention goes to req0.
